// File: rtl/tb_exit_ctrl_if.sv
// Exit-request handshake bundle: one valid/value/ready lane per hart.
interface tb_exit_ctrl_if #(
  parameter int NUM_HARTS = 1
);
  logic [NUM_HARTS-1:0]       exit_req_valid_i;
  logic [NUM_HARTS-1:0][31:0] exit_req_value_i;
  logic [NUM_HARTS-1:0]       exit_req_ready_o;

  modport master (
    output exit_req_valid_i,
    output exit_req_value_i,
    input  exit_req_ready_o
  );

  modport slave (
    input  exit_req_valid_i,
    input  exit_req_value_i,
    output exit_req_ready_o
  );
endinterface

// File: rtl/tb_exit_ctrl.sv
// Simulation exit controller: gathers per-hart exit requests or a watchdog
// timeout into one sticky exit code, and picks DPI vs pad JTAG at boot.
module tb_exit_ctrl #(
  parameter int          NUM_HARTS      = 1,
  parameter int          EXIT_MODE      = 0,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter logic [31:0] TIMEOUT_CODE   = 32'hDEAD_0001,
  parameter bit          USE_JTAG_DPI   = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [1:0]            boot_mode_i,
  input  logic                  heartbeat_i,
  tb_exit_ctrl_if.slave         req_if,
  output logic                  sim_jtag_enable_o,
  output logic                  exit_valid_o,
  output logic [31:0]           exit_value_o,
  output logic [2:0]            exit_src_o,
  output logic                  timeout_o
);

  // BOOT: sample boot mode | RUN: collect exits, watchdog runs | DONE: sticky result
  typedef enum logic [1:0] {S_BOOT, S_RUN, S_DONE} state_t;

  localparam logic [31:0] LP_TO_LAST =
    (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [NUM_HARTS-1:0]  r_reported;
  logic [NUM_HARTS-1:0]  w_ready;
  logic [NUM_HARTS-1:0]  w_acc;
  logic                  w_blk;
  logic                  w_cur_any;
  logic [2:0]            w_cur_idx;
  logic [31:0]           w_cur_val;
  logic                  w_nz_found;
  logic [2:0]            w_nz_idx;
  logic [31:0]           w_nz_val;
  logic                  w_take;
  logic                  w_m_found;
  logic [2:0]            w_m_idx;
  logic [31:0]           w_m_val;
  logic                  w_all_done;
  logic                  w_decide;
  logic                  w_wdog_clr;
  logic                  w_timeout;
  logic                  r_acc_found;
  logic [2:0]            r_acc_src;
  logic [31:0]           r_acc_val;
  logic [31:0]           r_wdog;
  logic                  r_jtag_en;
  logic                  r_exit_valid;
  logic [31:0]           r_exit_value;
  logic [2:0]            r_exit_src;
  logic                  r_timeout;

  // In first-wins mode a valid lower hart masks ready of every higher hart.
  always_comb begin
    w_ready = '0;
    w_blk   = 1'b0;
    if (r_state == S_RUN) begin
      for (int i = 0; i < NUM_HARTS; i++) begin
        w_ready[i] = ~r_reported[i] & ~w_blk;
        if (EXIT_MODE == 0 && req_if.exit_req_valid_i[i]) w_blk = 1'b1;
      end
    end
  end

  assign w_acc                   = req_if.exit_req_valid_i & w_ready;
  assign req_if.exit_req_ready_o = w_ready;

  always_comb begin
    w_cur_any  = 1'b0;
    w_cur_idx  = 3'd0;
    w_cur_val  = 32'd0;
    w_nz_found = 1'b0;
    w_nz_idx   = 3'd0;
    w_nz_val   = 32'd0;
    for (int i = NUM_HARTS - 1; i >= 0; i--) begin
      if (w_acc[i]) begin
        w_cur_any = 1'b1;
        w_cur_idx = 3'(i);
        w_cur_val = req_if.exit_req_value_i[i];
        if (req_if.exit_req_value_i[i] != 32'd0) begin
          w_nz_found = 1'b1;
          w_nz_idx   = 3'(i);
          w_nz_val   = req_if.exit_req_value_i[i];
        end
      end
    end
  end

  // Harts may report out of order, so a later lower-index nonzero code replaces the held one.
  assign w_take     = w_nz_found && (!r_acc_found || (w_nz_idx < r_acc_src));
  assign w_m_found  = r_acc_found | w_nz_found;
  assign w_m_idx    = w_take ? w_nz_idx : r_acc_src;
  assign w_m_val    = w_take ? w_nz_val : r_acc_val;

  assign w_all_done = &(r_reported | w_acc);
  assign w_decide   = (EXIT_MODE == 0) ? w_cur_any : (w_cur_any & w_all_done);
  assign w_wdog_clr = heartbeat_i | w_cur_any;
  assign w_timeout  = (TIMEOUT_CYCLES != 0) && (r_state == S_RUN) &&
                      (r_wdog == LP_TO_LAST) && !w_wdog_clr;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_BOOT:  w_state_nxt = S_RUN;
      S_RUN:   if (w_decide || w_timeout) w_state_nxt = S_DONE;
      default: w_state_nxt = r_state;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_state <= S_BOOT;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_reported   <= '0;
      r_acc_found  <= 1'b0;
      r_acc_src    <= 3'd0;
      r_acc_val    <= 32'd0;
      r_wdog       <= 32'd0;
      r_jtag_en    <= 1'b0;
      r_exit_valid <= 1'b0;
      r_exit_value <= 32'd0;
      r_exit_src   <= 3'd0;
      r_timeout    <= 1'b0;
    end else begin
      if (r_state == S_BOOT) r_jtag_en <= (boot_mode_i == 2'd0) && USE_JTAG_DPI;
      if (r_state == S_RUN) begin
        r_reported  <= r_reported | w_acc;
        r_acc_found <= w_m_found;
        r_acc_src   <= w_m_idx;
        r_acc_val   <= w_m_val;
        if (w_wdog_clr)           r_wdog <= 32'd0;
        else if (r_wdog != '1)    r_wdog <= r_wdog + 32'd1;
        if (w_timeout) begin
          r_exit_valid <= 1'b1;
          r_exit_value <= TIMEOUT_CODE;
          r_exit_src   <= 3'd7;
          r_timeout    <= 1'b1;
        end else if (w_decide) begin
          r_exit_valid <= 1'b1;
          r_exit_value <= (EXIT_MODE == 0) ? w_cur_val : w_m_val;
          r_exit_src   <= (EXIT_MODE == 0) ? w_cur_idx : w_m_idx;
        end
      end
    end
  end

  assign sim_jtag_enable_o = r_jtag_en;
  assign exit_valid_o      = r_exit_valid;
  assign exit_value_o      = r_exit_value;
  assign exit_src_o        = r_exit_src;
  assign timeout_o         = r_timeout;

endmodule

// File: doc/tb_exit_ctrl.md
TB_EXIT_CTRL -- requirements
Module: tb_exit_ctrl

Interface
REQ-001 SHALL have parameter NUM_HARTS, default 1, number of exit-request channels (1..8).
REQ-002 SHALL have parameter EXIT_MODE, default 0, 0 = first exit wins, 1 = wait for all harts.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1_000_000, watchdog limit in cycles; 0 disables the watchdog.
REQ-004 SHALL have parameter TIMEOUT_CODE, default 32'hDEAD_0001, exit value reported on timeout.
REQ-005 SHALL have parameter USE_JTAG_DPI, default 1'b0, permits the JTAG DPI source.
REQ-006 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-007 SHALL have port rst_ni  input  1  reset, synchronous, active-low.
REQ-008 SHALL have port boot_mode_i  input  2  boot mode, sampled once after reset.
REQ-009 SHALL have port heartbeat_i  input  1  activity pulse; restarts the watchdog.
REQ-010 SHALL have port exit_req_valid_i  input  NUM_HARTS  per-hart exit request.
REQ-011 SHALL have port exit_req_value_i  input  NUM_HARTS x 32  per-hart exit code.
REQ-012 SHALL have port exit_req_ready_o  output  NUM_HARTS  per-hart accept.
REQ-013 SHALL have port sim_jtag_enable_o  output  1  select DPI JTAG over pad JTAG.
REQ-014 SHALL have port exit_valid_o  output  1  simulation finished; sticky.
REQ-015 SHALL have port exit_value_o  output  32  final exit code.
REQ-016 SHALL have port exit_src_o  output  3  hart index that decided exit_value_o.
REQ-017 SHALL have port timeout_o  output  1  exit caused by watchdog; sticky.

Function
REQ-018 FSM SHALL have states BOOT, RUN, DONE; reset enters BOOT.
REQ-019 BOOT SHALL last exactly one cycle, latch boot_mode_i into boot_mode_q, then go to RUN.
REQ-020 sim_jtag_enable_o SHALL be registered (boot_mode_q == 0 && USE_JTAG_DPI) from the cycle after BOOT until reset, ignoring later boot_mode_i changes.
REQ-021 In RUN, exit_req_ready_o[i] SHALL be 1 iff hart i has not yet reported; 0 in BOOT and DONE.
REQ-022 A request SHALL be accepted on a cycle with valid[i] && ready[i]; each hart is accepted at most once.
REQ-023 EXIT_MODE 0: the first accepted request SHALL move the FSM to DONE; simultaneous requests SHALL be resolved to the lowest index, and only that index is accepted (ready of others is deasserted that cycle via priority).
REQ-024 EXIT_MODE 1: all simultaneous valid requests SHALL be accepted in one cycle; DONE is entered on the cycle the last outstanding hart is accepted.
REQ-025 EXIT_MODE 1 result SHALL be the nonzero code of the lowest-index hart reporting nonzero, with exit_src_o that index; if all codes are zero, value 0 and exit_src_o 0.
REQ-026 exit_valid_o, exit_value_o, exit_src_o SHALL update one cycle after the deciding acceptance (registered), and hold until reset.
REQ-027 Watchdog counter (32-bit, saturating) SHALL count in RUN, clear on heartbeat_i and on each acceptance, and hold in BOOT and DONE.
REQ-028 When TIMEOUT_CYCLES != 0 and counter reaches TIMEOUT_CYCLES-1 with no heartbeat or acceptance that cycle, FSM SHALL go to DONE with exit_value_o = TIMEOUT_CODE, exit_src_o = 7, timeout_o = 1.
REQ-029 Acceptance and timeout in the same cycle: acceptance SHALL win, counter clears, timeout_o stays 0.
REQ-030 DONE SHALL be terminal until reset; requests in DONE are ignored.
REQ-031 Index widths SHALL support NUM_HARTS = 1 with no out-of-range indexing.

Reset
REQ-032 While rst_ni = 0 at a clock edge: FSM = BOOT, exit_req_ready_o = 0, exit_valid_o = 0, exit_value_o = 0, exit_src_o = 0, timeout_o = 0, sim_jtag_enable_o = 0, counter = 0, reported flags = 0.
REQ-033 Reset asserted mid-RUN or in DONE SHALL discard all collected results; boot mode is re-sampled after release.

Verification
REQ-034 NUM_HARTS=4, MODE 0: valid[2]=1 code 5 and valid[1]=1 code 9 same cycle -> only ready/accept hart1; next cycle exit_valid_o=1, value 9, src 1.
REQ-035 NUM_HARTS=4, MODE 1: harts report 0,0,3,7 over different cycles -> exit_valid_o one cycle after last; value 3, src 2.
REQ-036 TIMEOUT_CYCLES=100, no heartbeat -> exit_valid_o=1, timeout_o=1, value 32'hDEAD_0001, src 7, 100 cycles after RUN entry (+1 register).
REQ-037 TIMEOUT_CYCLES=100, heartbeat every 50 cycles for 1000 cycles -> no timeout; then hart0 code 0 -> value 0, timeout_o=0.
REQ-038 USE_JTAG_DPI=1, boot_mode_i=0 at BOOT then changed to 2 -> sim_jtag_enable_o stays 1; with boot_mode_i=1 at BOOT -> 0.
REQ-039 Reset asserted for one cycle in DONE -> all outputs 0 next cycle; new exit with code 4 reports 4.
